// File: rtl/reg_write_arbiter.sv
// Three-requester register write arbiter driving a SETUP/STROBE/HOLD/RELEASE write clock sequence.
// Define REG_WRITE_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority 0 > 1 > 2.
module reg_write_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic                 clock,
  input  logic                 resb,
  input  logic [2:0]           req,
  input  logic [11:0]          req_addr,
  input  logic [3*WIDTH-1:0]   req_data,
  output logic [2:0]           ack,
  output logic                 busy,
  output logic [1:0]           grant,
  output logic [WIDTH-1:0]     wr_d,
  output logic [NREG-1:0]      wr_sel,
  output logic                 wr_c
);

  // Handshake: a requester raises req[i] and holds it; ack[i] pulses for one
  // clock in RELEASE, and the requester must drop req[i] by the edge that
  // samples that ack or it is taken as a fresh request in the following IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]       winner;
  logic [3:0]       win_addr;
  logic [WIDTH-1:0] win_data;

  logic [2:0]       ack_nxt;
  logic             busy_nxt;
  logic [1:0]       grant_nxt;
  logic [WIDTH-1:0] wr_d_nxt;
  logic [NREG-1:0]  wr_sel_nxt;
  logic             wr_c_nxt;

  // Addresses at or beyond NREG decode to no select at all, dropping the write.
  function automatic logic [NREG-1:0] decode(input logic [3:0] addr);
    logic [NREG-1:0] sel;
    sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == 4'(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

`ifdef REG_WRITE_ARBITER_RR_EN
  logic [1:0] last_grant;

  always_comb begin
    case (last_grant)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resb) begin
      last_grant <= 2'd2;
    end else if (state == IDLE && req != 3'b000) begin
      last_grant <= winner;
    end
  end
`else
  always_comb begin
    winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  always_comb begin
    win_addr = req_addr[3:0];
    win_data = req_data[WIDTH-1:0];
    case (winner)
      2'd1: begin
        win_addr = req_addr[7:4];
        win_data = req_data[2*WIDTH-1:WIDTH];
      end
      2'd2: begin
        win_addr = req_addr[11:8];
        win_data = req_data[3*WIDTH-1:2*WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode; every output is a flop fed from here.
  always_comb begin
    state_nxt  = state;
    ack_nxt    = 3'b000;
    busy_nxt   = 1'b1;
    grant_nxt  = grant;
    wr_d_nxt   = wr_d;
    wr_sel_nxt = wr_sel;
    wr_c_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt   = 1'b0;
        wr_sel_nxt = '0;
        if (req != 3'b000) begin
          state_nxt  = SETUP;
          busy_nxt   = 1'b1;
          grant_nxt  = winner;
          wr_d_nxt   = win_data;
          wr_sel_nxt = decode(win_addr);
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        wr_c_nxt  = 1'b1;
      end
      STROBE: begin
        state_nxt = HOLD;
        wr_c_nxt  = 1'b1;
      end
      HOLD: begin
        state_nxt = RELEASE;
        ack_nxt   = 3'b001 << grant;
      end
      RELEASE: begin
        state_nxt  = IDLE;
        busy_nxt   = 1'b0;
        wr_sel_nxt = '0;
      end
      default: begin
        state_nxt  = IDLE;
        busy_nxt   = 1'b0;
        wr_sel_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resb) begin
      ack    <= 3'b000;
      busy   <= 1'b0;
      grant  <= 2'd2;
      wr_d   <= '0;
      wr_sel <= '0;
      wr_c   <= 1'b0;
    end else begin
      ack    <= ack_nxt;
      busy   <= busy_nxt;
      grant  <= grant_nxt;
      wr_d   <= wr_d_nxt;
      wr_sel <= wr_sel_nxt;
      wr_c   <= wr_c_nxt;
    end
  end

  a_ack_onehot: assert property (@(posedge clock) disable iff (!resb) $onehot0(ack));
  a_sel_onehot: assert property (@(posedge clock) disable iff (!resb) $onehot0(wr_sel));

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 16, range 1..16, giving the number of target registers.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resb, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 The block SHALL have port req, input, 3 bits: per-requester write request, level, held until ack.
REQ-006 The block SHALL have port req_addr, input, 12 bits: requester i register address in bits [4i+3:4i].
REQ-007 The block SHALL have port req_data, input, 3*WIDTH bits: requester i write data in bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-008 The block SHALL have port ack, output, 3 bits: one-clock completion pulse to the granted requester.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port grant, output, 2 bits: index of the current or most recent granted requester.
REQ-011 The block SHALL have port wr_d, output, WIDTH bits: data presented to the register bank.
REQ-012 The block SHALL have port wr_sel, output, NREG bits: one-hot register select.
REQ-013 The block SHALL have port wr_c, output, 1 bit: write clock to the selected register; the register captures on its 0->1 transition.

Function
REQ-014 The state machine SHALL have states IDLE, SETUP, STROBE, HOLD and RELEASE, and all outputs SHALL be registered.
REQ-015 In IDLE with any req bit high, the block SHALL select a winner, latch its address, data and index, and enter SETUP on the next edge.
REQ-016 In IDLE with req=000, the block SHALL remain in IDLE.
REQ-017 In SETUP, wr_d SHALL carry the latched data, wr_sel SHALL carry the decoded address, and wr_c SHALL be 0.
REQ-018 In STROBE and HOLD, wr_c SHALL be 1 while wr_d and wr_sel stay stable, giving a two-clock-wide write clock.
REQ-019 In RELEASE, wr_c SHALL be 0 with wr_d and wr_sel held, and ack[grant] SHALL be 1 for exactly that cycle.
REQ-020 The block SHALL always go RELEASE -> IDLE, giving at least one idle cycle between transactions.
REQ-021 The latency SHALL be: req sampled at edge N, with SETUP at N+1, STROBE at N+2, HOLD at N+3, RELEASE/ack at N+4, and IDLE at N+5.
REQ-022 In IDLE, wr_sel SHALL be all zero, wr_c SHALL be 0, and wr_d SHALL hold its last value.
REQ-023 A latched address >= NREG SHALL complete the full sequence including ack, but with wr_sel all zero (write dropped).
REQ-024 The requester SHALL drop req on the edge that samples its ack, otherwise it is treated as a new request.
REQ-025 req_addr and req_data changes after grant SHALL NOT affect the transaction in progress.
REQ-026 req changes outside IDLE SHALL be ignored until the next IDLE.

Reset
REQ-027 When resb=0 at a rising edge, in any state including mid-transaction, the block SHALL enter IDLE.
REQ-028 On reset, the block SHALL set wr_c=0, wr_sel=0, wr_d=0, ack=000, busy=0 and grant=2.
REQ-029 On reset, the round-robin last-grant pointer SHALL be set to 2, so requester 0 has first priority.
REQ-030 A transaction aborted by reset SHALL produce no ack.

Configuration
REQ-031 When macro REG_WRITE_ARBITER_RR_EN is defined, arbitration SHALL be round-robin: search order starts at (last grant + 1) mod 3, and the pointer updates on every grant.
REQ-032 When REG_WRITE_ARBITER_RR_EN is undefined, arbitration SHALL be fixed priority 0 > 1 > 2 and the pointer logic SHALL be absent.

Verification
REQ-033 After reset, req=001, addr0=5, data0=0xBEEF -> wr_sel=0x0020, wr_d=0xBEEF, wr_c high on edges N+2..N+3, ack=001 at N+4, busy low at N+5.
REQ-034 With req=111 held and each requester dropping on its ack, RR_EN defined -> grant order 0,1,2; RR_EN undefined -> 0,1,2 only because of the drop, and with requester 0 re-requesting after each ack -> 0,0,0.
REQ-035 resb=0 asserted during STROBE -> next cycle IDLE, wr_c=0, wr_sel=0, no ack pulse; the bench model register holds its value only if wr_c had not yet risen.
REQ-036 NREG=8, addr=12 -> full 5-state sequence, ack pulses, wr_sel=0, no register changes.
REQ-037 req_data changed from 0x1234 to 0x5678 during SETUP -> 0x1234 is written.
REQ-038 With req1 held continuously without dropping -> back-to-back transactions every 5 cycles, separated by exactly one IDLE cycle with busy=0.
